// File: rtl/dram_model_pipelined.sv
// dram_model_pipelined: behavioural DRAM backing store with a request FIFO and fixed read/write latencies.
// Define DRAM_PERF_COUNTERS_EN to add saturating rd_count/wr_count outputs.
module dram_model_pipelined #(
  parameter int ADDR_W = 32,
  parameter int DATA_BYTES = 8,
  parameter int MEM_BYTES = 65536,
  parameter int SRC_W = 4,
  parameter int DEPTH = 4,
  parameter int READ_LAT = 4,
  parameter int WRITE_LAT = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_type,
  input  logic [ADDR_W-1:0]       req_addr,
  input  logic [8*DATA_BYTES-1:0] req_payload,
  input  logic [SRC_W-1:0]        req_source,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [8*DATA_BYTES-1:0] rsp_data,
  output logic [SRC_W-1:0]        rsp_dest,
  output logic                    rsp_err,
  output logic                    err_valid,
`ifdef DRAM_PERF_COUNTERS_EN
  output logic [31:0]             rd_count,
  output logic [31:0]             wr_count,
`endif
  output logic [1:0]              err_code
);
  localparam int DW = 8*DATA_BYTES;
  localparam int AW = $clog2(DEPTH);
  localparam int MW = $clog2(MEM_BYTES);
  localparam int XW = ADDR_W + 1;
  localparam int LMAX = READ_LAT > WRITE_LAT ? READ_LAT : WRITE_LAT;
  localparam int CW = $clog2(LMAX + 1);
  typedef enum logic [2:0] {IDLE, RD_WAIT, WR_WAIT, RESP, ERR} state_t;
  state_t state, state_nx;
  logic [1:0] f_type [DEPTH];
  logic [ADDR_W-1:0] f_addr [DEPTH];
  logic [DW-1:0] f_data [DEPTH];
  logic [SRC_W-1:0] f_src [DEPTH];
  logic [7:0] mem [MEM_BYTES];
  logic [AW:0] wp, rp;
  logic [AW-1:0] hp;
  logic [1:0] op_type, op_code, h_code;
  logic [ADDR_W-1:0] op_addr, cur_addr;
  logic [DW-1:0] op_data, cur_data, rdata;
  logic [SRC_W-1:0] op_src, cur_src;
  logic [CW-1:0] cnt;
  logic empty, full, push, pop, h_oor, h_rd, h_wr, rd_last, wr_last, load_rsp, wr_commit;
  assign hp = rp[AW-1:0];
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign req_ready = reset_n && !full;
  assign push = req_valid && req_ready;
  assign pop = state == IDLE && !empty;
  // widened by one bit so addresses near the top of ADDR_W cannot wrap into range
  assign h_oor = ({1'b0, f_addr[hp]} + XW'(DATA_BYTES)) > XW'(MEM_BYTES);
  assign h_rd = f_type[hp] == 2'd0 && !h_oor;
  assign h_wr = f_type[hp] == 2'd1 && !h_oor;
  assign h_code = f_type[hp][1] ? 2'd2 : 2'd1;
  assign cur_addr = state == IDLE ? f_addr[hp] : op_addr;
  assign cur_data = state == IDLE ? f_data[hp] : op_data;
  assign cur_src = state == IDLE ? f_src[hp] : op_src;
  assign rd_last = state == RD_WAIT && int'(cnt) == READ_LAT - 2;
  assign wr_last = state == WR_WAIT && int'(cnt) == WRITE_LAT - 2;
  assign load_rsp = rd_last || (pop && h_rd && READ_LAT == 1);
  assign wr_commit = wr_last || (pop && h_wr && WRITE_LAT == 1);
  assign err_valid = state == ERR;
  assign err_code = err_valid ? op_code : 2'd0;
  always_comb begin
    rdata = '0;
    for (int i = 0; i < DATA_BYTES; i++) rdata[8*i +: 8] = mem[MW'(cur_addr) + MW'(i)];
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!empty) state_nx = h_rd ? (READ_LAT == 1 ? RESP : RD_WAIT) : h_wr ? (WRITE_LAT == 1 ? IDLE : WR_WAIT) : ERR;
      RD_WAIT: if (rd_last) state_nx = RESP;
      WR_WAIT: if (wr_last) state_nx = IDLE;
      RESP:    if (rsp_ready) state_nx = IDLE;
      ERR:     state_nx = op_type == 2'd0 ? RESP : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      op_type <= '0;
      op_code <= '0;
      op_addr <= '0;
      op_data <= '0;
      op_src <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_dest <= '0;
      rsp_err <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= state == IDLE ? '0 : cnt + 1'b1;
      if (push) wp <= wp + 1'b1;
      if (pop) begin
        rp <= rp + 1'b1;
        op_type <= f_type[hp];
        op_code <= h_code;
        op_addr <= f_addr[hp];
        op_data <= f_data[hp];
        op_src <= f_src[hp];
      end
      if (load_rsp) begin
        rsp_valid <= 1'b1;
        rsp_data <= rdata;
        rsp_dest <= cur_src;
        rsp_err <= 1'b0;
      end else if (state == ERR && op_type == 2'd0) begin
        rsp_valid <= 1'b1;
        rsp_data <= '0;
        rsp_dest <= op_src;
        rsp_err <= 1'b1;
      end else if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      f_type[wp[AW-1:0]] <= req_type;
      f_addr[wp[AW-1:0]] <= req_addr;
      f_data[wp[AW-1:0]] <= req_payload;
      f_src[wp[AW-1:0]] <= req_source;
    end
  end
  // storage survives reset, but a commit coinciding with reset is dropped
  always_ff @(posedge clk) begin
    if (reset_n && wr_commit)
      for (int i = 0; i < DATA_BYTES; i++) mem[MW'(cur_addr) + MW'(i)] <= cur_data[8*i +: 8];
  end
`ifdef DRAM_PERF_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (state == RESP && rsp_ready && rd_count != '1) rd_count <= rd_count + 1'b1;
      if (wr_commit && wr_count != '1) wr_count <= wr_count + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_dram_model_pipelined.sv
// tb_dram_model_pipelined: directed self-checking bench for dram_model_pipelined with default parameters.
module tb_dram_model_pipelined;
  localparam int READ_LAT = 4;
  localparam logic [63:0] P1 = 64'h1122334455667788;
  localparam logic [63:0] P2 = 64'hA0A1A2A3A4A5A6A7;
  localparam logic [63:0] P3 = 64'h0123456789ABCDEF;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [1:0] req_type = '0;
  logic [31:0] req_addr = '0;
  logic [63:0] req_payload = '0;
  logic [3:0] req_source = '0;
  logic rsp_valid;
  logic rsp_ready = 1'b0;
  logic [63:0] rsp_data;
  logic [3:0] rsp_dest;
  logic rsp_err;
  logic err_valid;
  logic [1:0] err_code;
`ifdef DRAM_PERF_COUNTERS_EN
  logic [31:0] rd_count, wr_count;
`endif
  int checks = 0;
  int errors = 0;
  int n;
  logic [31:0] fa [5];
  logic [63:0] fe [5];

  dram_model_pipelined dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_type(req_type), .req_addr(req_addr), .req_payload(req_payload), .req_source(req_source),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_dest(rsp_dest),
    .rsp_err(rsp_err), .err_valid(err_valid),
`ifdef DRAM_PERF_COUNTERS_EN
    .rd_count(rd_count), .wr_count(wr_count),
`endif
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [1:0] t, input logic [31:0] a, input logic [63:0] d, input logic [3:0] s);
    req_type = t;
    req_addr = a;
    req_payload = d;
    req_source = s;
    req_valid = 1'b1;
    for (int k = 0; k < 50 && !req_ready; k++) tick();
    chk("send_ready", 64'(req_ready), 64'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    while (!rsp_valid && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("rsp_seen", 64'(rsp_valid), 64'd1);
  endtask

  task automatic take();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    fa = '{32'h10, 32'h20, 32'hFFF8, 32'h21, 32'h10};
    fe = '{P1, 64'hFFA7, P3, 64'hFF, P1};
    @(negedge clk);
    tick();
    chk("reset_ready", 64'(req_ready), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_data", rsp_data, 64'd0);
    chk("reset_rsp_dest", 64'(rsp_dest), 64'd0);
    chk("reset_rsp_err", 64'(rsp_err), 64'd0);
    chk("reset_err_valid", 64'(err_valid), 64'd0);
    chk("reset_err_code", 64'(err_code), 64'd0);
    reset_n = 1'b1;
    tick();
    chk("post_reset_ready", 64'(req_ready), 64'd1);

    send(2'd1, 32'h10, P1, 4'd1);
    repeat (4) tick();
    send(2'd0, 32'h10, 64'd0, 4'd3);
    wait_rsp(n);
    chk("rd_latency", 64'(n), 64'(READ_LAT));
    chk("rd_data", rsp_data, P1);
    chk("rd_dest", 64'(rsp_dest), 64'd3);
    chk("rd_err", 64'(rsp_err), 64'd0);
    repeat (2) tick();
    chk("hold_valid", 64'(rsp_valid), 64'd1);
    chk("hold_data", rsp_data, P1);
    take();
    chk("rsp_released", 64'(rsp_valid), 64'd0);

    send(2'd1, 32'h20, P2, 4'd1);
    send(2'd1, 32'h21, 64'hFF, 4'd1);
    send(2'd0, 32'h20, 64'd0, 4'd2);
    wait_rsp(n);
    chk("unaligned_data", rsp_data, 64'hFFA7);
    take();

    send(2'd1, 32'hFFF8, P3, 4'd1);
    repeat (3) tick();
    send(2'd0, 32'hFFFC, 64'd0, 4'd5);
    tick();
    chk("oor_rd_err_valid", 64'(err_valid), 64'd1);
    chk("oor_rd_err_code", 64'(err_code), 64'd1);
    chk("oor_rd_no_rsp_yet", 64'(rsp_valid), 64'd0);
    tick();
    chk("oor_rd_pulse_end", 64'(err_valid), 64'd0);
    chk("oor_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("oor_rsp_err", 64'(rsp_err), 64'd1);
    chk("oor_rsp_data", rsp_data, 64'd0);
    chk("oor_rsp_dest", 64'(rsp_dest), 64'd5);
    take();
    send(2'd1, 32'hFFFC, 64'hEEEEEEEEEEEEEEEE, 4'd1);
    tick();
    chk("oor_wr_err_valid", 64'(err_valid), 64'd1);
    chk("oor_wr_err_code", 64'(err_code), 64'd1);
    tick();
    chk("oor_wr_no_rsp", 64'(rsp_valid), 64'd0);
    chk("oor_wr_pulse_end", 64'(err_valid), 64'd0);
    send(2'd0, 32'hFFFF_FFFC, 64'd0, 4'd6);
    tick();
    chk("wrap_err_code", 64'(err_code), 64'd1);
    tick();
    chk("wrap_rsp_err", 64'(rsp_err), 64'd1);
    take();
    send(2'd0, 32'hFFF8, 64'd0, 4'd6);
    wait_rsp(n);
    chk("top_edge_data", rsp_data, P3);
    chk("top_edge_err", 64'(rsp_err), 64'd0);
    take();

    send(2'd3, 32'h10, 64'd0, 4'd2);
    tick();
    chk("bad_type_err_valid", 64'(err_valid), 64'd1);
    chk("bad_type_err_code", 64'(err_code), 64'd2);
    tick();
    chk("bad_type_no_rsp", 64'(rsp_valid), 64'd0);
    chk("bad_type_pulse_end", 64'(err_valid), 64'd0);
    send(2'd0, 32'h10, 64'd0, 4'd7);
    wait_rsp(n);
    chk("after_bad_data", rsp_data, P1);
    chk("after_bad_dest", 64'(rsp_dest), 64'd7);
    chk("after_bad_err", 64'(rsp_err), 64'd0);
    take();
`ifdef DRAM_PERF_COUNTERS_EN
    chk("wr_count", 64'(wr_count), 64'd4);
`endif

    for (int i = 0; i < 5; i++) send(2'd0, fa[i], 64'd0, 4'(i + 1));
    chk("fifo_full_ready", 64'(req_ready), 64'd0);
    wait_rsp(n);
    repeat (3) tick();
    chk("stall_valid", 64'(rsp_valid), 64'd1);
    chk("stall_data", rsp_data, fe[0]);
    chk("stall_dest", 64'(rsp_dest), 64'd1);
    for (int i = 0; i < 5; i++) begin
      wait_rsp(n);
      chk("drain_data", rsp_data, fe[i]);
      chk("drain_dest", 64'(rsp_dest), 64'(i + 1));
      take();
    end
    repeat (2) tick();
    chk("drain_ready", 64'(req_ready), 64'd1);
    chk("drain_idle", 64'(rsp_valid), 64'd0);

    send(2'd1, 32'h10, 64'hDEADBEEFCAFEF00D, 4'd1);
    tick();
    reset_n = 1'b0;
    tick();
    chk("midreset_ready", 64'(req_ready), 64'd0);
    chk("midreset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midreset_err_valid", 64'(err_valid), 64'd0);
`ifdef DRAM_PERF_COUNTERS_EN
    chk("midreset_rd_count", 64'(rd_count), 64'd0);
    chk("midreset_wr_count", 64'(wr_count), 64'd0);
`endif
    reset_n = 1'b1;
    repeat (3) tick();
    chk("postreset_ready", 64'(req_ready), 64'd1);
    chk("postreset_empty", 64'(rsp_valid), 64'd0);
    chk("postreset_no_err", 64'(err_valid), 64'd0);
    send(2'd0, 32'h10, 64'd0, 4'd9);
    wait_rsp(n);
    chk("dropped_write_data", rsp_data, P1);
    chk("dropped_write_dest", 64'(rsp_dest), 64'd9);
    take();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dram_model_pipelined.md
Name: dram_model_pipelined

Overview:
- Parametrised behavioural DRAM model that sits on the CPU memory bus as the backing store for global memory.
- Accepts read and write request packets through a valid/ready handshake.
- Applies configurable read and write latencies, returns read data tagged with the requester's source ID, and buffers up to DEPTH pending requests.
- Out-of-range and unknown commands are reported on an error output and never stop simulation.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_BYTES, 8, payload width in bytes (payload bits = 8*DATA_BYTES).
- MEM_BYTES, 65536, storage size in bytes.
- SRC_W, 4, width of source/destination ID.
- DEPTH, 4, request FIFO depth (power of two, >=2).
- READ_LAT, 4, cycles from FIFO pop to response valid (>=1).
- WRITE_LAT, 2, cycles from FIFO pop to write commit (>=1).

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO can accept.
- req_type  in  2  0=read, 1=write, others illegal.
- req_addr  in  ADDR_W  byte address.
- req_payload  in  8*DATA_BYTES  write data.
- req_source  in  SRC_W  requester ID.
- rsp_valid  out  1  read response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  8*DATA_BYTES  read data.
- rsp_dest  out  SRC_W  echoed req_source.
- rsp_err  out  1  response carries an out-of-range error.
- err_valid  out  1  one-cycle pulse on an illegal request.
- err_code  out  2  1=out-of-range, 2=unknown type.

Behaviour:
- Reset (reset_n low at a rising clk edge):
  - FIFO emptied; FSM to IDLE.
  - req_ready=0 during the reset cycle, then 1.
  - rsp_valid=0, rsp_data=0, rsp_dest=0, rsp_err=0, err_valid=0, err_code=0.
  - Storage contents are not cleared.
  - Reset mid-operation abandons any in-flight op. A write not yet committed is dropped.
- Enqueue:
  - A request transfers when req_valid && req_ready.
  - req_ready = !fifo_full.
  - Simultaneous push and pop when full is not allowed: ready is deasserted when full.
- FSM states:
  - IDLE: if FIFO is non-empty, pop the head and decode it.
    - Legal read -> RD_WAIT.
    - Legal write -> WR_WAIT.
    - Illegal -> ERR.
  - RD_WAIT: counter counts READ_LAT-1 cycles, then → RESP, with rsp_valid=1 and data assembled.
  - RESP: hold rsp_valid/rsp_data/rsp_dest/rsp_err stable until rsp_ready. On the handshake cycle → IDLE.
  - WR_WAIT: counter counts WRITE_LAT-1 cycles. On the final cycle commit all bytes, then → IDLE.
  - ERR: err_valid=1 for exactly one cycle with err_code.
    - Out-of-range read → RESP with rsp_err=1 and rsp_data=0.
    - Any other illegal request → IDLE.
- Only one operation is in flight at a time. Pop-to-pop minimum spacing is READ_LAT+1 cycles (reads) and WRITE_LAT cycles (writes).
- Legal address: req_addr + DATA_BYTES <= MEM_BYTES, evaluated at ADDR_W+1 bits so there is no wrap-around. Violation gives err_code=1; memory is untouched.
- Unknown type (2,3) gives err_code=2 and produces no response.
- Byte order is little-endian:
  - Read: rsp_data[8i+7:8i] = storage[addr+i].
  - Write: storage[addr+i] = payload[8i+7:8i], for i in 0..DATA_BYTES-1.
- Unaligned addresses are legal.
- Ordering: strict FIFO order. A read following a write to the same address returns the new data, because the write commits before the next pop.

Optional Feature:
- Macro: DRAM_PERF_COUNTERS_EN.
- Defined: adds outputs rd_count and wr_count (32 bits each).
  - rd_count increments on each read response handshake.
  - wr_count increments on each write commit.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Write addr 0x10, payload 0x1122334455667788, then read 0x10 from source 3 → rsp_data=0x1122334455667788, rsp_dest=3, rsp_err=0. rsp_valid rises exactly READ_LAT cycles after the read pop.
- Unaligned write at 0x21 with payload 0xFF, then read 0x20 → byte1=0xFF, byte0 = prior contents.
- Read at MEM_BYTES-4 (DATA_BYTES=8) → err_valid pulse with err_code=1, then rsp_err=1 and rsp_data=0. A write at the same address → err pulse only, storage unchanged.
- req_type=3 → err_code=2, no response; the next legal read completes normally.
- Fill DEPTH+1 requests with rsp_ready held 0 → req_ready=0 after DEPTH+1 accepts (one popped). Responses hold stable; releasing rsp_ready drains them in order.
- reset_n low for 1 cycle during WR_WAIT → the write is not committed, rsp_valid=0, FIFO empty. With DRAM_PERF_COUNTERS_EN, the counters read 0.
